// File: rtl/sync_cell_pkg.sv
// rtl/sync_cell_pkg.sv - shared types and helpers for the sync cell lock arbiter
//
// Purpose: arbiter FSM state encoding and the actor-ID width helper shared by
//          the arbiter and anything that consumes its locked_to select.
// Contents:
//   sc_arb_state_t   SC_IDLE / SC_LOCKED / SC_REVOKE
//   actor_id_bits()  width of an actor ID select, $clog2(actors+1)
package sync_cell_pkg;

    typedef enum logic [1:0] {
        SC_IDLE   = 2'd0,
        SC_LOCKED = 2'd1,
        SC_REVOKE = 2'd2
    } sc_arb_state_t;

    // The cell's mux select reserves one spare code above the last actor,
    // so the ID width is sized for actors+1 values.
    function automatic int actor_id_bits(input int actors);
        return $clog2(actors + 1);
    endfunction

endpackage

// File: rtl/sync_cell_rr_arbiter_rr_pick.sv
// rtl/sync_cell_rr_arbiter_rr_pick.sv - combinational round-robin find-first picker
//
// Purpose: find the first set request at or above ptr, wrapping N-1 -> 0.
// Ports:
//   req    in   N   request vector (already masked for eligibility)
//   ptr    in   W   search start position, always < N
//   valid  out  1   at least one request set
//   index  out  W   winning position (0 when valid is low)
module rr_pick #(
    parameter int N = 16,
    parameter int W = 5
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    logic [N-1:0] rotated;
    logic [W-1:0] offset;
    logic [W:0]   sum;

    always_comb begin
        // Rotate right by ptr so the search start lands at bit 0.
        rotated = N'({req, req} >> ptr);

        // Downward scan so the lowest set bit is the last one written.
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end

        valid = |req;

        // Un-rotate: ptr + offset modulo N, both operands are below N.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end
        index = sum[W-1:0];
    end

endmodule

// File: rtl/sync_cell_rr_arbiter.sv
// rtl/sync_cell_rr_arbiter.sv - round-robin lock arbiter with hold-time limit
//
// Purpose: grants a shared sync cell to one of ACTORS requesters in round-robin
//          order and forcibly revokes a lock held for MAX_HOLD cycles.
// Ports:
//   clk        in   1         clock
//   rst        in   1         asynchronous active-high reset
//   lock_reqs  in   ACTORS    level request per actor
//   is_locked  out  1         lock currently granted
//   locked_to  out  ID_BITS   owning actor (0 when not locked)
//   grant      out  ACTORS    one-hot of locked_to while locked, else zero
//   revoked    out  1         one-cycle pulse on forced revoke
//   hold_cnt   out  CNT_BITS  cycles the current owner has held the lock
module sync_cell_rr_arbiter
    import sync_cell_pkg::*;
#(
    parameter int  ACTORS   = 16,
    parameter int  MAX_HOLD = 64,
    localparam int ID_BITS  = actor_id_bits(ACTORS),
    localparam int CNT_BITS = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ACTORS-1:0]   lock_reqs,
    output logic                is_locked,
    output logic [ID_BITS-1:0]  locked_to,
    output logic [ACTORS-1:0]   grant,
    output logic                revoked,
    output logic [CNT_BITS-1:0] hold_cnt
);

    // With the limit disabled the counter just saturates at its top value.
    localparam logic [CNT_BITS-1:0] CNT_SAT =
        (MAX_HOLD == 0) ? {CNT_BITS{1'b1}} : CNT_BITS'(MAX_HOLD);

    sc_arb_state_t       state_q, state_d;
    logic [ID_BITS-1:0]  owner_q, owner_d;
    logic [ID_BITS-1:0]  ptr_q, ptr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [ACTORS-1:0]   blocked_q, blocked_d;
    logic [ACTORS-1:0]   set_block;

    logic [ACTORS-1:0]   eligible;
    logic [ACTORS-1:0]   owner_mask;
    logic                owner_req;
    logic [ID_BITS-1:0]  next_ptr;
    logic                pick_valid;
    logic [ID_BITS-1:0]  pick_index;

    assign eligible   = lock_reqs & ~blocked_q;
    assign owner_mask = {{(ACTORS - 1){1'b0}}, 1'b1} << owner_q;
    assign owner_req  = |(lock_reqs & owner_mask);
    assign next_ptr   = (owner_q == ID_BITS'(ACTORS - 1)) ? '0 : owner_q + ID_BITS'(1);

    rr_pick #(
        .N (ACTORS),
        .W (ID_BITS)
    ) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        set_block = '0;

        case (state_q)
            SC_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = SC_LOCKED;
                    owner_d = pick_index;
                    cnt_d   = CNT_BITS'(1);
                end
            end
            SC_LOCKED: begin
                // A voluntary release takes priority over hold expiry.
                if (!owner_req) begin
                    state_d = SC_IDLE;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end else if ((MAX_HOLD != 0) && (cnt_q == CNT_SAT)) begin
                    state_d   = SC_REVOKE;
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    set_block = owner_mask;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            SC_REVOKE: begin
                // Dead cycle: nobody is granted while the revoke is signalled.
                state_d = SC_IDLE;
            end
            default: begin
                state_d = SC_IDLE;
            end
        endcase

        // A blocked actor becomes eligible again only after dropping its request.
        blocked_d = (blocked_q | set_block) & lock_reqs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SC_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            blocked_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
        end
    end

    assign is_locked = (state_q == SC_LOCKED);
    assign revoked   = (state_q == SC_REVOKE);
    assign locked_to = is_locked ? owner_q : '0;
    assign grant     = is_locked ? owner_mask : '0;
    assign hold_cnt  = cnt_q;

endmodule

// File: tb/tb_sync_cell_rr_arbiter.sv
// tb/tb_sync_cell_rr_arbiter.sv - self-checking bench for sync_cell_rr_arbiter
module tb_sync_cell_rr_arbiter;

    localparam int N    = 16;
    localparam int MAXH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lock_reqs = '0;
    logic        is_locked;
    logic [4:0]  locked_to;
    logic [15:0] grant;
    logic        revoked;
    logic [2:0]  hold_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sync_cell_rr_arbiter #(
        .ACTORS   (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock_reqs (lock_reqs),
        .is_locked (is_locked),
        .locked_to (locked_to),
        .grant     (grant),
        .revoked   (revoked),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the lock, for how long, where the next
    // round-robin search starts and which actors are locked out.
    bit          m_locked  = 1'b0;
    bit          m_revoked = 1'b0;
    int          m_owner   = 0;
    int          m_cnt     = 0;
    int          m_ptr     = 0;
    logic [15:0] m_blocked = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] r;
        logic [15:0] nb;
        bit          found;
        int          a;
        if (rst) begin
            m_locked  = 1'b0;
            m_revoked = 1'b0;
            m_owner   = 0;
            m_cnt     = 0;
            m_ptr     = 0;
            m_blocked = '0;
        end else begin
            r  = lock_reqs;
            nb = m_blocked;
            if (m_revoked) begin
                m_revoked = 1'b0;
            end else if (m_locked) begin
                if (!r[m_owner]) begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                    m_ptr    = (m_owner + 1) % N;
                end else if (m_cnt == MAXH) begin
                    m_locked      = 1'b0;
                    m_revoked     = 1'b1;
                    m_cnt         = 0;
                    nb[m_owner]   = 1'b1;
                    m_ptr         = (m_owner + 1) % N;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    a = (m_ptr + k) % N;
                    if (!found && r[a] && !m_blocked[a]) begin
                        found   = 1'b1;
                        m_owner = a;
                    end
                end
                if (found) begin
                    m_locked = 1'b1;
                    m_cnt    = 1;
                end
            end
            m_blocked = nb & r;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("is_locked", int'(is_locked), int'(m_locked));
            chk("revoked", int'(revoked), int'(m_revoked));
            chk("hold_cnt", int'(hold_cnt), m_cnt);
            chk("grant", int'(grant), m_locked ? int'(16'h1 << m_owner) : 0);
            if (m_locked) begin
                chk("locked_to", int'(locked_to), m_owner);
            end
            if (is_locked) begin
                chk("grant_onehot", int'(grant), int'(16'h1 << locked_to));
            end
        end
    end

    task automatic cyc(input logic [15:0] r);
        @(negedge clk);
        #1;
        lock_reqs = r;
    endtask

    task automatic wait_locked(input logic [15:0] r, output int idle_cycles);
        idle_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (is_locked) return;
            idle_cycles++;
            lock_reqs = r;
        end
        chk("lock_timeout", 0, 1);
    endtask

    initial begin
        int idle;
        int exp_owner;
        logic [15:0] r;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_is_locked", int'(is_locked), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_hold_cnt", int'(hold_cnt), 0);
        chk("rst_revoked", int'(revoked), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset asserted mid-cycle while locked with everyone requesting.
        wait_locked(16'hFFFF, idle);
        chk("pre_rst_owner", int'(locked_to), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_is_locked", int'(is_locked), 0);
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_hold_cnt", int'(hold_cnt), 0);
        repeat (2) cyc(16'hFFFF);
        chk("rst_held_idle", int'(is_locked), 0);
        lock_reqs = 16'h0000;
        cyc(16'h0000);
        rst = 1'b0;
        cyc(16'h0000);

        // Fairness: 0 and 2 alternate; also exactly one idle cycle between.
        for (int g = 0; g < 4; g++) begin
            exp_owner = (g % 2 == 0) ? 0 : 2;
            wait_locked(16'h0005, idle);
            chk("fair_owner", int'(locked_to), exp_owner);
            chk("fair_hold1", int'(hold_cnt), 1);
            if (g > 0) chk("idle_gap", idle, 1);
            cyc(16'h0005);
            chk("fair_hold2", int'(hold_cnt), 2);
            r = 16'h0005 & ~(16'h1 << exp_owner);
            cyc(r);
            chk("fair_hold3", int'(hold_cnt), 3);
        end
        repeat (3) cyc(16'h0000);

        // Wrap: 14 releases so the search starts at 15.
        wait_locked(16'h4000, idle);
        chk("wrap_owner14", int'(locked_to), 14);
        cyc(16'h8001);
        wait_locked(16'h8001, idle);
        chk("wrap_owner15", int'(locked_to), 15);
        cyc(16'h0001);
        wait_locked(16'h0001, idle);
        chk("wrap_owner0", int'(locked_to), 0);
        repeat (3) cyc(16'h0000);

        // Hold limit: 3 holds forever, 5 waits.
        wait_locked(16'h0028, idle);
        chk("hold_owner3", int'(locked_to), 3);
        for (int h = 2; h <= MAXH; h++) begin
            cyc(16'h0028);
            chk("hold_count", int'(hold_cnt), h);
        end
        cyc(16'h0028);
        chk("revoke_pulse", int'(revoked), 1);
        chk("revoke_unlocked", int'(is_locked), 0);
        cyc(16'h0028);
        chk("revoke_done", int'(revoked), 0);
        chk("dead_cycle", int'(is_locked), 0);
        cyc(16'h0028);
        chk("after_revoke_owner", int'(locked_to), 5);
        cyc(16'h0008);
        cyc(16'h0008);
        cyc(16'h0008);
        chk("blocked_stays_idle", int'(is_locked), 0);
        cyc(16'h0000);
        wait_locked(16'h0008, idle);
        chk("unblocked_owner3", int'(locked_to), 3);

        // Collision: owner drops exactly as the hold limit is reached.
        cyc(16'h0008);
        cyc(16'h0008);
        cyc(16'h0000);
        chk("coll_hold_max", int'(hold_cnt), MAXH);
        cyc(16'h0000);
        chk("coll_no_revoke", int'(revoked), 0);
        chk("coll_released", int'(is_locked), 0);
        wait_locked(16'h0008, idle);
        chk("coll_regrant3", int'(locked_to), 3);
        repeat (3) cyc(16'h0000);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                @(negedge clk);
                #3;
                rst = 1'b1;
                repeat (2) cyc(16'($urandom));
                rst = 1'b0;
            end
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) cyc(16'($urandom) & 16'($urandom));
                else cyc(16'($urandom));
            end else begin
                cyc(lock_reqs);
            end
        end
        cyc(16'h0000);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
